// File: rtl/fifo_burst_reader.sv
// FIFO read-port consumer: pulls words into a 2-entry skid buffer and frames them as BURST_LEN-beat bursts.
// Optional `FIFO_RDR_STATS_EN adds saturating beat/burst counters (word_cnt_o, burst_cnt_o).
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = $clog2(BURST_LEN+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  empty_i,
  input  logic                  underflow_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rd_en_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  error_o
`ifdef FIFO_RDR_STATS_EN
  ,
  output logic [15:0]           word_cnt_o,
  output logic [15:0]           burst_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [CNT_WIDTH-1:0] BL_C   = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_C = CNT_WIDTH'(BURST_LEN-1);

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   issued_q;
  logic [CNT_WIDTH-1:0]   beat_q;
  logic                   inflight_q;
  logic                   error_q;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
  logic                   pop;
  logic [2:0]             pending;

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf0_q;
  assign m_last_o  = m_valid_o && (beat_q == LAST_C);
  assign pop       = m_valid_o && m_ready_i;
  assign busy_o    = (state_q != IDLE);
  assign error_o   = error_q;

  // Words already owned (buffered or in flight) minus the one leaving this cycle must leave room.
  assign pending = 3'(occ_q) + 3'(inflight_q);
  assign rd_en_o = (state_q == RUN) && !empty_i && (pending < (3'd2 + 3'(pop))) &&
                   (issued_q < BL_C);

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({pop, inflight_q})
      2'b01: begin
        if (occ_q == 2'd0) buf0_d = rd_data_i;
        else               buf1_d = rd_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b10: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = rd_data_i;
        end else begin
          buf0_d = rd_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf0_q <= '0;
      buf1_q <= '0;
      occ_q  <= '0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      inflight_q <= rd_en_o;
      if (underflow_i) error_q <= 1'b1;
      if (pop) beat_q <= m_last_o ? '0 : beat_q + CNT_WIDTH'(1);
      case (state_q)
        IDLE: begin
          issued_q <= '0;
          if (enable_i && !empty_i) state_q <= RUN;
        end
        RUN: begin
          if (rd_en_o) begin
            issued_q <= issued_q + CNT_WIDTH'(1);
            if (issued_q == LAST_C) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last_o) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RDR_STATS_EN
  logic [15:0] word_cnt_q;
  logic [15:0] burst_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (pop && (word_cnt_q != 16'hFFFF)) word_cnt_q <= word_cnt_q + 16'd1;
      if (pop && m_last_o && (burst_cnt_q != 16'hFFFF)) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign word_cnt_o  = word_cnt_q;
  assign burst_cnt_o = burst_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, stream scoreboard, cycle table and directed corner cases.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_i, enable_i, empty_i, underflow_i, m_ready_i;
  logic [DW-1:0] rd_data_i;
  logic          rd_en_o, m_valid_o, m_last_o, busy_o, error_o;
  logic [DW-1:0] m_data_o;
`ifdef FIFO_RDR_STATS_EN
  logic [15:0]   word_cnt_o, burst_cnt_o;
`endif

  fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .empty_i(empty_i),
    .underflow_i(underflow_i), .rd_data_i(rd_data_i), .rd_en_o(rd_en_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o), .error_o(error_o)
`ifdef FIFO_RDR_STATS_EN
    , .word_cnt_o(word_cnt_o), .burst_cnt_o(burst_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, rdy;
    logic          rd, v;
    logic [DW-1:0] d;
    logic          l, busy;
  } vec_t;

  int            nchk = 0, nerr = 0;
  int            acc_cnt = 0, rd_cnt = 0;
  logic [DW-1:0] fifo[$], exp_q[$], acc_q[$];
  logic          acc_l[$];
  logic          smp_rd, smp_v, smp_l, smp_busy, smp_err;
  logic [DW-1:0] smp_d;
  logic          hold = 1'b0, hold_l;
  logic [DW-1:0] hold_d;
  vec_t          tbl[16];
  logic [DW-1:0] c_exp[4];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", n, act, req);
    end
  endtask

  function automatic vec_t mk(logic en, logic rdy, logic rd, logic v, logic [DW-1:0] d,
                              logic l, logic busy);
    vec_t r;
    r.en = en; r.rdy = rdy; r.rd = rd; r.v = v; r.d = d; r.l = l; r.busy = busy;
    return r;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fifo.push_back(w);
    empty_i = 1'b0;
  endtask

  // One clock: sample and score at negedge, then play the FIFO's side after posedge.
  task automatic step();
    logic [DW-1:0] w;
    @(negedge clk);
    smp_rd = rd_en_o; smp_v = m_valid_o; smp_d = m_data_o; smp_l = m_last_o;
    smp_busy = busy_o; smp_err = error_o;
    if (smp_rd === 1'b1) begin
      rd_cnt++;
      chk("rd_when_empty", 32'(fifo.size() == 0), 0);
    end
    if (hold === 1'b1) begin
      chk("hold_valid", smp_v, 1);
      chk("hold_data", smp_d, hold_d);
      chk("hold_last", smp_l, hold_l);
    end
    hold = smp_v && !m_ready_i; hold_d = smp_d; hold_l = smp_l;
    if (smp_v === 1'b1 && m_ready_i) begin
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL sb_extra_beat: actual=%0h required=none", smp_d);
      end else begin
        w = exp_q.pop_front();
        chk("sb_data", smp_d, w);
      end
      chk("sb_last", smp_l, 32'((acc_cnt % BL) == BL-1));
      acc_cnt++;
      acc_q.push_back(smp_d);
      acc_l.push_back(smp_l);
    end
    @(posedge clk); #1;
    if (smp_rd === 1'b1 && fifo.size() > 0) begin
      w = fifo.pop_front();
      rd_data_i = w;
      exp_q.push_back(w);
    end else begin
      rd_data_i = DW'($urandom);
    end
    empty_i = (fifo.size() == 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b0; m_ready_i = 1'b0; underflow_i = 1'b0;
    step();
    rst_i = 1'b0; hold = 1'b0;
    fifo.delete(); exp_q.delete(); acc_q.delete(); acc_l.delete();
    acc_cnt = 0; rd_cnt = 0; empty_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; empty_i = 1'b1; underflow_i = 1'b0;
    m_ready_i = 1'b0; rd_data_i = '0;

    // Reset state
    do_reset();
    step();
    chk("rst_valid", smp_v, 0);
    chk("rst_last", smp_l, 0);
    chk("rst_data", smp_d, 0);
    chk("rst_busy", smp_busy, 0);
    chk("rst_err", smp_err, 0);
    chk("rst_rd", smp_rd, 0);

    // Two back-to-back bursts, cycle exact
    tbl[0]  = mk(1, 1, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    tbl[2]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    tbl[3]  = mk(1, 1, 1, 1, 8'h10, 0, 1);
    tbl[4]  = mk(1, 1, 1, 1, 8'h11, 0, 1);
    tbl[5]  = mk(1, 1, 0, 1, 8'h12, 0, 1);
    tbl[6]  = mk(1, 1, 0, 1, 8'h13, 1, 1);
    tbl[7]  = mk(1, 1, 0, 0, 8'h00, 0, 0);
    tbl[8]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    tbl[9]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    tbl[10] = mk(1, 1, 1, 1, 8'h14, 0, 1);
    tbl[11] = mk(1, 1, 1, 1, 8'h15, 0, 1);
    tbl[12] = mk(1, 1, 0, 1, 8'h16, 0, 1);
    tbl[13] = mk(1, 1, 0, 1, 8'h17, 1, 1);
    tbl[14] = mk(1, 1, 0, 0, 8'h00, 0, 0);
    tbl[15] = mk(1, 1, 0, 0, 8'h00, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
    for (int i = 0; i < 16; i++) begin
      enable_i = tbl[i].en; m_ready_i = tbl[i].rdy;
      step();
      chk($sformatf("t%0d_rd", i), smp_rd, tbl[i].rd);
      chk($sformatf("t%0d_valid", i), smp_v, tbl[i].v);
      chk($sformatf("t%0d_last", i), smp_l, tbl[i].l);
      chk($sformatf("t%0d_busy", i), smp_busy, tbl[i].busy);
      if (tbl[i].v) chk($sformatf("t%0d_data", i), smp_d, tbl[i].d);
    end
`ifdef FIFO_RDR_STATS_EN
    chk("t_word_cnt", word_cnt_o, 8);
    chk("t_burst_cnt", burst_cnt_o, 2);
`endif

    // Backpressure: only two reads, head held
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'(8'h10 + i));
    enable_i = 1'b1; m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (smp_v) chk("b_hold_head", smp_d, 8'h10);
    end
    chk("b_rd_pulses", rd_cnt, 2);
    m_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("b_beats", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      chk("b_data", acc_q[i], 32'(8'h10 + i));
      chk("b_last", acc_l[i], 32'(i == 3));
    end
    chk("b_idle", busy_o, 0);

    // FIFO runs dry mid-burst
    do_reset();
    push(8'hA0); push(8'hA1);
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("c_gap_valid", smp_v, 0);
      chk("c_gap_busy", smp_busy, 1);
    end
    push(8'hA2); push(8'hA3);
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc_q.size() < 4) chk("c_busy", smp_busy, 1);
    end
    c_exp[0] = 8'hA0; c_exp[1] = 8'hA1; c_exp[2] = 8'hA2; c_exp[3] = 8'hA3;
    chk("c_beats", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      chk("c_data", acc_q[i], c_exp[i]);
      chk("c_last", acc_l[i], 32'(i == 3));
    end

    // enable dropped after the first beat
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h20 + i));
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() == 0; i++) step();
    enable_i = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("d_beats", acc_q.size(), 4);
    if (acc_q.size() >= 4) chk("d_last", acc_l[3], 1);
    chk("d_busy", smp_busy, 0);
    chk("d_rd_total", rd_cnt, 4);
    chk("d_fifo_left", fifo.size(), 4);

    // Reset mid-burst with two words buffered
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'(8'h30 + i));
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() == 0; i++) step();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("e_pre_valid", smp_v, 1);
    do_reset();
    step();
    chk("e_valid", smp_v, 0);
    chk("e_busy", smp_busy, 0);
    for (int i = 0; i < 4; i++) push(DW'(8'h40 + i));
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("e_beats", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      chk("e_data", acc_q[i], 32'(8'h40 + i));
      chk("e_last", acc_l[i], 32'(i == 3));
    end

    // Sticky error
    do_reset();
    step();
    chk("f_err_clear", smp_err, 0);
    underflow_i = 1'b1;
    step();
    underflow_i = 1'b0;
    step();
    chk("f_err_set", smp_err, 1);
    for (int i = 0; i < 5; i++) step();
    chk("f_err_hold", smp_err, 1);
    do_reset();
    step();
    chk("f_err_rst", smp_err, 0);

`ifdef FIFO_RDR_STATS_EN
    do_reset();
    for (int i = 0; i < 12; i++) push(DW'(i));
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("s_word_cnt", word_cnt_o, 12);
    chk("s_burst_cnt", burst_cnt_o, 3);
`endif

    // Random traffic against the scoreboard
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      enable_i  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) != 0 && fifo.size() < 16) push(DW'($urandom));
      step();
    end
    enable_i = 1'b0; m_ready_i = 1'b1;
    for (int c = 0; c < 200 && busy_o; c++) begin
      if (fifo.size() == 0) push(DW'($urandom));
      step();
    end
    chk("r_idle", busy_o, 0);
    chk("r_whole_bursts", 32'(acc_cnt % BL), 0);
    chk("r_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Single-clock consumer for the read port of the team's FIFOs: rd_en/rd_data/empty/underflow on one side, valid/ready stream on the other.
- Pulls words whenever the FIFO is non-empty and local space exists.
- Frames the stream into fixed-length bursts, with m_last_o on the final beat.
- Sits between a FIFO read domain and downstream packet logic (DMA/serializer).

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- BURST_LEN, 4, beats per burst; must be >= 1.
- CNT_WIDTH, $clog2(BURST_LEN+1), width of the burst counters.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  synchronous, active-high reset.
- enable_i  input  1  permission to start a new burst; sampled only in IDLE.
- empty_i  input  1  FIFO empty flag.
- underflow_i  input  1  FIFO underflow pulse.
- rd_data_i  input  DATA_WIDTH  FIFO read data; valid the cycle after the FIFO samples rd_en_o.
- rd_en_o  output  1  FIFO read request; combinational.
- m_valid_o  output  1  stream valid.
- m_data_o  output  DATA_WIDTH  stream data.
- m_last_o  output  1  final beat of the burst.
- m_ready_i  input  1  downstream ready.
- busy_o  output  1  high whenever state != IDLE.
- error_o  output  1  sticky; set if underflow_i is seen.

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE; all counters 0; skid buffer empty.
  - m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, error_o=0.
  - A reset mid-burst discards buffered and in-flight words.
- Read latency:
  - rd_en_o=1 in cycle N means the word is present on rd_data_i in cycle N+1.
  - That word is captured into the skid buffer at the end of cycle N+1.
  - inflight register = rd_en_o delayed by one cycle.
- Skid buffer:
  - 2 entries.
  - Head drives m_data_o; m_valid_o = occupancy != 0.
  - A pop (m_valid_o && m_ready_i) and a capture in the same cycle both occur; occupancy is unchanged.
- rd_en_o = (state==RUN) && !empty_i && (occupancy + inflight - pop) < 2 && issued < BURST_LEN.
  - The buffer never overflows.
  - Full throughput: 1 beat/cycle while m_ready_i=1 and the FIFO is non-empty.
- FSM:
  - IDLE: issued=0. Go to RUN when enable_i && !empty_i.
  - RUN: issued increments on each rd_en_o. When issued reaches BURST_LEN, go to DRAIN.
  - DRAIN: no reads issued. When the beat with m_last_o is accepted, go to IDLE.
- Beat counter: increments on each accepted beat. m_last_o = m_valid_o && (beat == BURST_LEN-1). Clears to 0 when the last beat is accepted.
- Empty mid-burst: reads stall, the burst stays open indefinitely, and m_valid_o drops once the buffer drains. There is no padding.
- enable_i deasserted mid-burst: ignored; the current burst always completes.
- BURST_LEN=1: every beat carries m_last_o.
- Stream rule: m_data_o and m_last_o are held stable while m_valid_o && !m_ready_i.
- underflow_i: sets error_o, which holds until reset. Data flow is otherwise unaffected.

Optional Feature:
- Macro: FIFO_RDR_STATS_EN.
- Defined:
  - Adds outputs word_cnt_o [15:0] and burst_cnt_o [15:0].
  - word_cnt_o counts accepted beats; burst_cnt_o counts accepted last-beats.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then FIFO preloaded with 8'h10..8'h17, enable_i=1, m_ready_i=1 → reads issued back-to-back; beats 10,11,12,13 with last on 13; then 14..17 with last on 17. busy_o=0 once the FIFO is empty, after the second burst.
- m_ready_i=0 with 4 words available → rd_en_o pulses exactly twice, then stays 0. m_data_o=8'h10 held stable. After m_ready_i=1, all 4 beats arrive in order with no loss or duplication.
- FIFO holds only 2 words mid-burst; empty_i=1 for 10 cycles, then 2 more words (8'hA2, 8'hA3) arrive → m_valid_o low during the gap; m_last_o only on 8'hA3; busy_o high throughout.
- enable_i dropped after the first beat → remaining 3 beats delivered, FSM returns to IDLE, and no further rd_en_o while enable_i=0 even though empty_i=0.
- rst_i asserted mid-burst with 2 words buffered → next cycle m_valid_o=0 and busy_o=0; a new burst restarts beat count at 0.
- underflow_i pulsed for 1 cycle → error_o=1 and holds until rst_i. With FIFO_RDR_STATS_EN: after 3 bursts of 4, word_cnt_o=12 and burst_cnt_o=3.
